// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates hazard, branch, mult/div and halt requests.
// Latency: controls are combinational (Mealy) from state and inputs; they take effect at the same clock edge.
// Backpressure: holds PC/IF/ID/ID/EX for mult/div (MD_LAT cycles) and drain/halt; a resume pulse releases HALTED.
//
// Ports: clk/reset (synchronous, active-high); requests hz_stall, br_taken, md_start, halt_req, resume;
//        controls pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_bubble; status md_done, halted;
//        performance counters stall_cnt/flush_cnt, present only when PIPE_PERF_CNT_EN is defined (else tied to 0).
module pipeline_stall_ctrl #(
    parameter int MD_LAT       = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hz_stall,
    input  logic             br_taken,
    input  logic             md_start,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_hold,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             md_done,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, MD_BUSY, DRAIN, HALTED} state_t;

    state_t         state, nextState;
    logic [MW-1:0]  mdCnt, nextMdCnt;
    logic [DW-1:0]  drainCnt, nextDrainCnt;
    logic           runArb;
    logic           mdIgnore;

    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        md_done      = 1'b0;
        halted       = 1'b0;
        nextState    = state;
        nextMdCnt    = mdCnt;
        nextDrainCnt = drainCnt;
        runArb       = 1'b0;
        mdIgnore     = 1'b0;

        case (state)
            RUN: runArb = 1'b1;
            MD_BUSY: begin
                if (mdCnt != '0) begin
                    pc_hold      = 1'b1;
                    ifid_hold    = 1'b1;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    nextMdCnt    = mdCnt - MW'(1);
                end else begin
                    // Release cycle: the held mult/div advances at this edge, so its
                    // still-high md_start must not retrigger; other requests arbitrate as in RUN.
                    md_done   = 1'b1;
                    nextState = RUN;
                    runArb    = 1'b1;
                    mdIgnore  = 1'b1;
                end
            end
            DRAIN: begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_flush = 1'b1;
                if (drainCnt == '0) begin
                    nextState = HALTED;
                end else begin
                    nextDrainCnt = drainCnt - DW'(1);
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    // Flush the halt instruction still sitting in IF/ID and let the PC run.
                    ifid_flush = 1'b1;
                    nextState  = RUN;
                end else begin
                    pc_hold    = 1'b1;
                    ifid_hold  = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            default: nextState = RUN;
        endcase

        if (runArb) begin
            if (md_start && !mdIgnore) begin
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                idex_hold    = 1'b1;
                exmem_bubble = 1'b1;
                nextMdCnt    = MW'(MD_LAT - 1);
                nextState    = MD_BUSY;
            end else if (hz_stall) begin
                // Stall beats branch flush: ifid_hold and ifid_flush never coexist.
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_flush = 1'b1;
            end else if (br_taken) begin
                ifid_flush = 1'b1;
            end else if (halt_req) begin
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                idex_flush   = 1'b1;
                nextDrainCnt = DW'(DRAIN_CYCLES - 1);
                nextState    = DRAIN;
            end
        end

        if (reset) begin
            pc_hold      = 1'b0;
            ifid_hold    = 1'b0;
            ifid_flush   = 1'b0;
            idex_hold    = 1'b0;
            idex_flush   = 1'b0;
            exmem_bubble = 1'b0;
            md_done      = 1'b0;
            halted       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            mdCnt    <= '0;
            drainCnt <= '0;
        end else begin
            state    <= nextState;
            mdCnt    <= nextMdCnt;
            drainCnt <= nextDrainCnt;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stallCntQ, flushCntQ;

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (pc_hold && (stallCntQ != '1)) stallCntQ <= stallCntQ + CNT_W'(1);
            if (ifid_flush && (flushCntQ != '1)) flushCntQ <= flushCntQ + CNT_W'(1);
        end
    end

    assign stall_cnt = stallCntQ;
    assign flush_cnt = flushCntQ;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: default instance plus a minimum-latency, 4-bit-counter instance.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 3ns after it.
// Backpressure: none; every sequence is a fixed number of cycles.
module tb_pipeline_stall_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector bit order: pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_bubble, md_done, halted
    localparam logic [7:0] NONE    = 8'b0000_0000;
    localparam logic [7:0] STALL   = 8'b1100_1000;
    localparam logic [7:0] MDH     = 8'b1101_0100;
    localparam logic [7:0] FLUSH   = 8'b0010_0000;
    localparam logic [7:0] DONE    = 8'b0000_0010;
    localparam logic [7:0] DONEBR  = 8'b0010_0010;
    localparam logic [7:0] HALTST  = 8'b1100_1001;
    localparam logic [7:0] RESUMED = 8'b0010_0001;

    logic clk = 1'b0;
    logic reset, hzStall, brTaken, mdStart, haltReq, resume;

    logic        pcHoldA, ifidHoldA, ifidFlushA, idexHoldA, idexFlushA, exmemBubbleA, mdDoneA, haltedA;
    logic [31:0] stallCntA, flushCntA;
    logic        pcHoldB, ifidHoldB, ifidFlushB, idexHoldB, idexFlushB, exmemBubbleB, mdDoneB, haltedB;
    logic [3:0]  stallCntB, flushCntB;
    logic [7:0]  ctlA, ctlB;

    int errCnt = 0;
    int chkCnt = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MD_LAT(4), .DRAIN_CYCLES(3), .CNT_W(32)) dutA (
        .clk(clk), .reset(reset), .hz_stall(hzStall), .br_taken(brTaken), .md_start(mdStart),
        .halt_req(haltReq), .resume(resume), .pc_hold(pcHoldA), .ifid_hold(ifidHoldA),
        .ifid_flush(ifidFlushA), .idex_hold(idexHoldA), .idex_flush(idexFlushA),
        .exmem_bubble(exmemBubbleA), .md_done(mdDoneA), .halted(haltedA),
        .stall_cnt(stallCntA), .flush_cnt(flushCntA)
    );

    pipeline_stall_ctrl #(.MD_LAT(1), .DRAIN_CYCLES(1), .CNT_W(4)) dutB (
        .clk(clk), .reset(reset), .hz_stall(hzStall), .br_taken(brTaken), .md_start(mdStart),
        .halt_req(haltReq), .resume(resume), .pc_hold(pcHoldB), .ifid_hold(ifidHoldB),
        .ifid_flush(ifidFlushB), .idex_hold(idexHoldB), .idex_flush(idexFlushB),
        .exmem_bubble(exmemBubbleB), .md_done(mdDoneB), .halted(haltedB),
        .stall_cnt(stallCntB), .flush_cnt(flushCntB)
    );

    assign ctlA = {pcHoldA, ifidHoldA, ifidFlushA, idexHoldA, idexFlushA, exmemBubbleA, mdDoneA, haltedA};
    assign ctlB = {pcHoldB, ifidHoldB, ifidFlushB, idexHoldB, idexFlushB, exmemBubbleB, mdDoneB, haltedB};

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive request inputs (at edge+1ns) and let the Mealy outputs settle.
    task automatic setIn(input logic h, input logic b, input logic m, input logic hr, input logic r);
        hzStall = h; brTaken = b; mdStart = m; haltReq = hr; resume = r;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] perfExp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    initial begin
        reset = 1'b1;
        hzStall = 1'b0; brTaken = 1'b0; mdStart = 1'b0; haltReq = 1'b0; resume = 1'b0;
        tick();

        // Reset cycle with a live stall request: outputs forced low.
        setIn(1, 0, 0, 0, 0);
        checkVal("rst_ctl", 32'(ctlA), 32'(NONE));
        tick();
        reset = 1'b0;
        setIn(0, 0, 0, 0, 0);
        checkVal("rst_idle", 32'(ctlA), 32'(NONE));
        checkVal("rst_stall_cnt", stallCntA, 32'd0);
        checkVal("rst_flush_cnt", flushCntA, 32'd0);
        tick();

        // Single-cycle hazard stall.
        setIn(1, 0, 0, 0, 0);
        checkVal("hz_stall", 32'(ctlA), 32'(STALL));
        tick();
        setIn(0, 0, 0, 0, 0);
        checkVal("hz_release", 32'(ctlA), 32'(NONE));
        checkVal("hz_stall_cnt", stallCntA, perfExp(1));
        tick();

        // Stall beats branch flush, then branch alone flushes.
        setIn(1, 1, 0, 0, 0);
        checkVal("hz_over_br", 32'(ctlA), 32'(STALL));
        tick();
        setIn(0, 1, 0, 0, 0);
        checkVal("br_flush", 32'(ctlA), 32'(FLUSH));
        checkVal("br_flush_cnt_pre", flushCntA, 32'd0);
        tick();
        setIn(0, 0, 0, 0, 0);
        checkVal("br_idle", 32'(ctlA), 32'(NONE));
        checkVal("br_flush_cnt", flushCntA, perfExp(1));
        checkVal("br_stall_cnt", stallCntA, perfExp(2));
        tick();

        // Mult/div with md_start held: 4 hold cycles, release cycle with a branch applied.
        setIn(0, 0, 1, 0, 0);
        checkVal("md_t0", 32'(ctlA), 32'(MDH));
        checkVal("md1_t0", 32'(ctlB), 32'(MDH));
        tick();
        setIn(0, 0, 1, 0, 0);
        checkVal("md_t1", 32'(ctlA), 32'(MDH));
        checkVal("md1_done", 32'(ctlB), 32'(DONE));
        tick();
        setIn(0, 0, 1, 0, 0);
        checkVal("md_t2", 32'(ctlA), 32'(MDH));
        tick();
        setIn(0, 0, 1, 0, 0);
        checkVal("md_t3", 32'(ctlA), 32'(MDH));
        tick();
        setIn(0, 1, 1, 0, 0);
        checkVal("md_done_br", 32'(ctlA), 32'(DONEBR));
        tick();
        setIn(0, 0, 0, 0, 0);
        checkVal("md_back_run", 32'(ctlA), 32'(NONE));
        checkVal("md_stall_cnt", stallCntA, perfExp(6));
        checkVal("md_flush_cnt", flushCntA, perfExp(2));
        tick();

        // Reset while in MD_BUSY with md_cnt=2.
        setIn(0, 0, 1, 0, 0);
        checkVal("mdr_t0", 32'(ctlA), 32'(MDH));
        tick();
        setIn(0, 0, 1, 0, 0);
        checkVal("mdr_t1", 32'(ctlA), 32'(MDH));
        tick();
        reset = 1'b1;
        setIn(0, 0, 1, 0, 0);
        checkVal("mdr_reset_ctl", 32'(ctlA), 32'(NONE));
        tick();
        reset = 1'b0;
        setIn(0, 0, 0, 0, 1);
        checkVal("mdr_after_rst", 32'(ctlA), 32'(NONE));
        checkVal("mdr_stall_cnt", stallCntA, 32'd0);
        checkVal("mdr_flush_cnt", flushCntA, 32'd0);
        tick();

        // Halt, drain (other requests ignored), halted, resume.
        setIn(0, 0, 0, 1, 0);
        checkVal("halt_req", 32'(ctlA), 32'(STALL));
        tick();
        setIn(1, 1, 1, 0, 0);
        checkVal("drain_1", 32'(ctlA), 32'(STALL));
        tick();
        setIn(0, 0, 0, 0, 0);
        checkVal("drain_2", 32'(ctlA), 32'(STALL));
        checkVal("drain1_halted", 32'(ctlB), 32'(HALTST));
        tick();
        setIn(0, 0, 0, 0, 0);
        checkVal("drain_3", 32'(ctlA), 32'(STALL));
        tick();
        setIn(0, 0, 0, 0, 0);
        checkVal("halted", 32'(ctlA), 32'(HALTST));
        tick();
        setIn(0, 0, 0, 0, 1);
        checkVal("resume", 32'(ctlA), 32'(RESUMED));
        tick();
        setIn(0, 0, 0, 0, 0);
        checkVal("after_resume", 32'(ctlA), 32'(NONE));
        checkVal("halt_stall_cnt", stallCntA, perfExp(5));
        checkVal("halt_flush_cnt", flushCntA, perfExp(1));
        tick();

        // Counter saturation on the 4-bit instance.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            setIn(1, 0, 0, 0, 0);
            tick();
        end
        setIn(0, 0, 0, 0, 0);
        checkVal("sat_cnt4", 32'(stallCntB), perfExp(15));
        checkVal("sat_cnt32", stallCntA, perfExp(20));
        checkVal("sat_idle", 32'(ctlB), 32'(NONE));
        tick();

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Inputs: combinational requests from the hazard detector (load-use / branch-operand stall), the ID-stage branch/jump resolver, the EX-stage multi-cycle mult/div unit, and the halt (syscall) decoder.
- Priority-arbitrates these requests and times multi-cycle events with an FSM and counters.
- Drives the PC, IF/ID, ID/EX and EX/MEM hold/flush controls.

Parameters:
- MD_LAT, 4, mult/div latency in cycles (>=1); EX is held this many cycles.
- DRAIN_CYCLES, 3, cycles of bubble insertion before HALTED (>=1).
- CNT_W, 32, width of performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- hz_stall  input  1  stall request from the hazard detector.
- br_taken  input  1  branch/jump in ID resolved as taken.
- md_start  input  1  mult/div instruction present in EX; stays high while that instruction is held.
- halt_req  input  1  halt/syscall decoded in ID.
- resume  input  1  one-cycle pulse that restarts from HALTED.
- pc_hold  output  1  freeze PC.
- ifid_hold  output  1  freeze IF/ID.
- ifid_flush  output  1  zero IF/ID at the next edge.
- idex_hold  output  1  freeze ID/EX.
- idex_flush  output  1  load a bubble into ID/EX.
- exmem_bubble  output  1  load a bubble into EX/MEM.
- md_done  output  1  final (release) cycle of a mult/div.
- halted  output  1  core halted.
- stall_cnt  output  CNT_W  cycles with pc_hold=1.
- flush_cnt  output  CNT_W  cycles with ifid_flush=1.

Behaviour:
- Outputs are Mealy: combinational from state, counter and inputs. Controls take effect at the same clock edge.
- Reset: state to RUN, md/drain counters to 0, stall_cnt/flush_cnt to 0. All control outputs are forced to 0 during any cycle with reset=1.
- Reset mid-operation (MD_BUSY, DRAIN or HALTED) returns to RUN with no residual holds.
- States: RUN, MD_BUSY, DRAIN, HALTED.
- RUN, evaluated in priority order:
  - (1) md_start: pc_hold=ifid_hold=idex_hold=exmem_bubble=1. Load md_cnt=MD_LAT-1. Go to MD_BUSY.
  - (2) hz_stall: pc_hold=ifid_hold=idex_flush=1. br_taken is ignored this cycle; stall beats flush.
  - (3) br_taken: ifid_flush=1 only; PC advances to the target.
  - (4) halt_req: pc_hold=ifid_hold=idex_flush=1. Load drain_cnt=DRAIN_CYCLES-1. Go to DRAIN.
  - else all controls 0.
- MD_BUSY:
  - md_cnt!=0: same four holds as RUN(1); decrement md_cnt.
  - md_cnt==0: md_done=1, no md holds, go to RUN. md_start is ignored in this cycle; the instruction advances at the edge.
  - In the md_cnt==0 cycle, hz_stall, br_taken and halt_req are applied exactly as RUN (2)-(4).
  - Total EX hold is exactly MD_LAT cycles, counting the RUN entry cycle.
- DRAIN: pc_hold=ifid_hold=idex_flush=1. Decrement drain_cnt; at 0 go to HALTED. Other inputs are ignored.
- HALTED: halted=1, pc_hold=ifid_hold=idex_flush=1.
  - resume=1: ifid_flush=1, pc_hold=0, ifid_hold=0, idex_flush=0. This discards the halt instruction. Go to RUN.
  - resume outside HALTED is ignored.
- Invariant: ifid_hold and ifid_flush are never both 1; hold wins (stall case).
- Counters: +1 per cycle that the condition is true; saturate at all-ones and never wrap.

Optional Feature:
- PIPE_PERF_CNT_EN defined: stall_cnt and flush_cnt implemented as described.
- Not defined: no counter registers; stall_cnt and flush_cnt tied to 0. All other behaviour is identical.

Test Plan:
- reset, then hz_stall=1 for 1 cycle -> that cycle pc_hold=ifid_hold=idex_flush=1; next cycle all 0; stall_cnt=1.
- hz_stall=1 and br_taken=1 same cycle -> ifid_flush=0, pc_hold=1; next cycle with br_taken=1 alone -> ifid_flush=1; flush_cnt=1.
- MD_LAT=4, md_start held high from cycle T -> exmem_bubble=idex_hold=1 in T..T+3; md_done=1 at T+4 with no holds; state RUN at T+5; no retrigger at T+4.
- halt_req=1 in RUN -> DRAIN for 3 cycles with idex_flush=1, then halted=1; resume pulse -> ifid_flush=1, pc_hold=0 that cycle; halted=0 next cycle.
- reset asserted during MD_BUSY (md_cnt=2) -> outputs 0 that cycle; next cycle RUN, md_start=0 gives all controls 0; counters 0.
- CNT_W=4 with PIPE_PERF_CNT_EN, hz_stall held 20 cycles -> stall_cnt saturates at 15; without macro stall_cnt=0 throughout.
